// File: rtl/commit_unit.sv
// Commit back end: retires one ROB entry per cycle into the register file,
// store queue and branch predictor, and sequences flush/redirect on mispredict.
module commit_unit #(
  parameter int SQ_DEPTH     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        globalReset,
  input  logic        validCommit,
  input  logic [31:0] result,
  input  logic [31:0] destCommit,
  input  logic [3:0]  commitInfo,
  input  logic [7:0]  controlFlow,
  input  logic [31:0] oldPC,
  input  logic [31:0] targetAddress,
  input  logic [31:0] statusSnap,
  input  logic [7:0]  previousIndex,
  input  logic        memAck,
  output logic        commitHold,
  output logic        regWe,
  output logic [4:0]  regAddr,
  output logic [31:0] regData,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        phtWe,
  output logic [7:0]  phtIndex,
  output logic [1:0]  phtState,
  output logic        btbWe,
  output logic [31:0] btbPC,
  output logic [31:0] btbTarget,
  output logic        flush,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic [31:0] statusRestore,
  output logic [31:0] instrRetired,
  output logic        sqOverflow
);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;

  logic [31:0]   sq_addr [SQ_DEPTH];
  logic [31:0]   sq_data [SQ_DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] count, cnt_n, left;
  logic [FW-1:0] fcnt;

  logic reg_write, mem_write, is_ctl, write_btb, taken, redirect;
  logic accept, push, pop, full, do_push;

  assign reg_write = commitInfo[3];
  assign mem_write = commitInfo[2];
  assign is_ctl    = controlFlow[7];
  assign write_btb = controlFlow[4];
  assign taken     = controlFlow[3];
  assign redirect  = controlFlow[2] | controlFlow[1];

  assign accept  = validCommit && (state == RUN);
  assign push    = accept && mem_write;
  assign pop     = memReq && memAck;
  assign full    = (count == CW'(SQ_DEPTH));
  assign do_push = push && (!full || pop);
  assign left    = count - CW'(pop);

  always_comb begin
    cnt_n  = count;
    rptr_n = pop ? rptr + PW'(1) : rptr;
    if (do_push && !pop)      cnt_n = count + CW'(1);
    else if (!do_push && pop) cnt_n = count - CW'(1);
  end

  // Queue storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      sq_addr[wptr] <= destCommit;
      sq_data[wptr] <= result;
    end
  end

  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      state         <= RUN;
      fcnt          <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      commitHold    <= 1'b0;
      regWe         <= 1'b0;
      regAddr       <= '0;
      regData       <= '0;
      memReq        <= 1'b0;
      memAddr       <= '0;
      memData       <= '0;
      phtWe         <= 1'b0;
      phtIndex      <= '0;
      phtState      <= '0;
      btbWe         <= 1'b0;
      btbPC         <= '0;
      btbTarget     <= '0;
      flush         <= 1'b0;
      redirectValid <= 1'b0;
      redirectPC    <= '0;
      statusRestore <= '0;
      instrRetired  <= '0;
      sqOverflow    <= 1'b0;
    end else begin
      regWe         <= accept && reg_write && (destCommit[4:0] != 5'd0);
      phtWe         <= accept && is_ctl;
      btbWe         <= accept && is_ctl && write_btb;
      redirectValid <= 1'b0;
      if (accept) begin
        instrRetired <= instrRetired + 32'd1;
        regAddr      <= destCommit[4:0];
        regData      <= result;
        if (is_ctl) begin
          phtIndex <= previousIndex;
          phtState <= controlFlow[6:5];
          if (write_btb) begin
            btbPC     <= oldPC;
            btbTarget <= targetAddress;
          end
        end
      end

      // Store queue; head output is registered so the new head is chosen
      // from next-state pointers, bypassing the incoming entry when empty.
      if (do_push) wptr <= wptr + PW'(1);
      if (push && full && !pop) sqOverflow <= 1'b1;
      rptr       <= rptr_n;
      count      <= cnt_n;
      commitHold <= (cnt_n >= CW'(SQ_DEPTH - 1));
      memReq     <= (cnt_n != '0);
      if (cnt_n != '0) begin
        if (left == '0) begin
          memAddr <= destCommit;
          memData <= result;
        end else begin
          memAddr <= sq_addr[rptr_n];
          memData <= sq_data[rptr_n];
        end
      end

      case (state)
        RUN: begin
          if (accept && is_ctl && redirect) begin
            state         <= FLUSH;
            fcnt          <= FW'(FLUSH_CYCLES - 1);
            flush         <= 1'b1;
            redirectValid <= 1'b1;
            redirectPC    <= taken ? targetAddress : oldPC + 32'd4;
            statusRestore <= statusSnap;
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            fcnt <= fcnt - FW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: register write, store queue, overflow,
// flush/redirect, predictor update and asynchronous reset mid-flush.
module tb_commit_unit;
  logic        clk = 1'b0;
  logic        globalReset;
  logic        validCommit;
  logic [31:0] result, destCommit, oldPC, targetAddress, statusSnap;
  logic [3:0]  commitInfo;
  logic [7:0]  controlFlow, previousIndex;
  logic        memAck;
  logic        commitHold, regWe, memReq, phtWe, btbWe, flush, redirectValid, sqOverflow;
  logic [4:0]  regAddr;
  logic [31:0] regData, memAddr, memData, btbPC, btbTarget, redirectPC, statusRestore, instrRetired;
  logic [7:0]  phtIndex;
  logic [1:0]  phtState;

  int checks = 0;
  int errors = 0;

  commit_unit #(.SQ_DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .globalReset(globalReset), .validCommit(validCommit),
    .result(result), .destCommit(destCommit), .commitInfo(commitInfo),
    .controlFlow(controlFlow), .oldPC(oldPC), .targetAddress(targetAddress),
    .statusSnap(statusSnap), .previousIndex(previousIndex), .memAck(memAck),
    .commitHold(commitHold), .regWe(regWe), .regAddr(regAddr), .regData(regData),
    .memReq(memReq), .memAddr(memAddr), .memData(memData),
    .phtWe(phtWe), .phtIndex(phtIndex), .phtState(phtState),
    .btbWe(btbWe), .btbPC(btbPC), .btbTarget(btbTarget),
    .flush(flush), .redirectValid(redirectValid), .redirectPC(redirectPC),
    .statusRestore(statusRestore), .instrRetired(instrRetired), .sqOverflow(sqOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] info, input logic [7:0] cf,
                       input logic [31:0] dest, input logic [31:0] res);
    validCommit = 1'b1;
    commitInfo  = info;
    controlFlow = cf;
    destCommit  = dest;
    result      = res;
  endtask

  task automatic idle();
    validCommit = 1'b0;
    commitInfo  = '0;
    controlFlow = '0;
  endtask

  initial begin
    globalReset = 1'b0; validCommit = 1'b0; result = '0; destCommit = '0;
    commitInfo = '0; controlFlow = '0; oldPC = '0; targetAddress = '0;
    statusSnap = '0; previousIndex = '0; memAck = 1'b0;
    tick(); tick();
    chk("rst_regWe", 32'(regWe), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_retired", instrRetired, 32'd0);
    chk("rst_hold", 32'(commitHold), 32'd0);
    globalReset = 1'b1;
    tick();

    // ALU commit, then same with r0
    drive(4'b1000, 8'h00, 32'd5, 32'hDEADBEEF);
    tick(); idle();
    chk("alu_we", 32'(regWe), 32'd1);
    chk("alu_addr", 32'(regAddr), 32'd5);
    chk("alu_data", regData, 32'hDEADBEEF);
    chk("alu_retired", instrRetired, 32'd1);
    tick();
    chk("alu_we_pulse", 32'(regWe), 32'd0);
    drive(4'b1000, 8'h00, 32'd0, 32'hDEADBEEF);
    tick(); idle();
    chk("r0_we", 32'(regWe), 32'd0);
    chk("r0_retired", instrRetired, 32'd2);

    // Three stores held back, then drained in order
    memAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 8'h00, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
      tick();
      if (i == 0) begin
        chk("st_req_first", 32'(memReq), 32'd1);
        chk("st_addr_first", memAddr, 32'h100);
      end
      if (i == 1) chk("st_hold_cnt2", 32'(commitHold), 32'd0);
    end
    idle();
    chk("st_hold_cnt3", 32'(commitHold), 32'd1);
    chk("st_retired", instrRetired, 32'd5);
    memAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", 32'(memReq), 32'd1);
      chk("drain_addr", memAddr, 32'h100 + 32'(4 * i));
      chk("drain_data", memData, 32'h1000 + 32'(i));
      tick();
      if (i == 0) chk("drain_hold_cnt2", 32'(commitHold), 32'd0);
    end
    chk("drain_empty", 32'(memReq), 32'd0);

    // Overflow: fifth store into a full queue is dropped
    memAck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, 8'h00, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
      if (i == 3) chk("ov_not_yet", 32'(sqOverflow), 32'd0);
    end
    idle();
    chk("ov_flag", 32'(sqOverflow), 32'd1);
    chk("ov_head", memAddr, 32'h200);
    memAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ov_drain_addr", memAddr, 32'h200 + 32'(4 * i));
      chk("ov_drain_data", memData, 32'hA0 + 32'(i));
      tick();
    end
    memAck = 1'b0;
    chk("ov_empty", 32'(memReq), 32'd0);
    chk("ov_sticky", 32'(sqOverflow), 32'd1);
    chk("ov_retired", instrRetired, 32'd10);

    // Mispredict, not taken: redirect to oldPC+4; commits during flush ignored
    oldPC = 32'h40; statusSnap = 32'h55; targetAddress = 32'h999;
    drive(4'b0001, 8'h84, 32'd0, 32'd0);
    tick();
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_rv", 32'(redirectValid), 32'd1);
    chk("mp_pc", redirectPC, 32'h44);
    chk("mp_status", statusRestore, 32'h55);
    chk("mp_pht", 32'(phtWe), 32'd1);
    drive(4'b1000, 8'h00, 32'd7, 32'h1234);
    tick();
    chk("mp_flush2", 32'(flush), 32'd1);
    chk("mp_rv2", 32'(redirectValid), 32'd0);
    chk("mp_ign_we", 32'(regWe), 32'd0);
    tick(); idle();
    chk("mp_flush_end", 32'(flush), 32'd0);
    chk("mp_ign_we2", 32'(regWe), 32'd0);
    chk("mp_retired", instrRetired, 32'd11);
    chk("mp_pc_hold", redirectPC, 32'h44);
    tick();

    // Misdirect, taken: redirect to target
    oldPC = 32'h60; targetAddress = 32'h300; statusSnap = 32'h77;
    drive(4'b0010, 8'h8A, 32'd0, 32'd0);
    tick(); idle();
    chk("md_pc", redirectPC, 32'h300);
    chk("md_status", statusRestore, 32'h77);
    tick(); tick();
    chk("md_done", 32'(flush), 32'd0);

    // Predictor and BTB update
    oldPC = 32'h80; targetAddress = 32'h200; previousIndex = 8'h3A;
    drive(4'b0001, 8'hF0, 32'd0, 32'd0);
    tick(); idle();
    chk("bp_pht_we", 32'(phtWe), 32'd1);
    chk("bp_pht_idx", 32'(phtIndex), 32'h3A);
    chk("bp_pht_st", 32'(phtState), 32'd3);
    chk("bp_btb_we", 32'(btbWe), 32'd1);
    chk("bp_btb_pc", btbPC, 32'h80);
    chk("bp_btb_tgt", btbTarget, 32'h200);
    chk("bp_no_flush", 32'(flush), 32'd0);
    tick();
    chk("bp_pht_pulse", 32'(phtWe), 32'd0);
    chk("bp_btb_pulse", 32'(btbWe), 32'd0);

    // Reset mid-flush with two queued stores
    memAck = 1'b0;
    drive(4'b0100, 8'h00, 32'h400, 32'h1);
    tick();
    drive(4'b0100, 8'h00, 32'h404, 32'h2);
    tick();
    oldPC = 32'h90; statusSnap = 32'h33;
    drive(4'b0001, 8'h84, 32'd0, 32'd0);
    tick(); idle();
    chk("pre_rst_flush", 32'(flush), 32'd1);
    #2 globalReset = 1'b0;
    #1;
    chk("ar_flush", 32'(flush), 32'd0);
    chk("ar_memReq", 32'(memReq), 32'd0);
    chk("ar_retired", instrRetired, 32'd0);
    chk("ar_pc", redirectPC, 32'd0);
    chk("ar_status", statusRestore, 32'd0);
    chk("ar_pht", 32'(phtWe), 32'd0);
    tick();
    globalReset = 1'b1;
    tick();
    drive(4'b1000, 8'h00, 32'd3, 32'hCAFE);
    tick(); idle();
    chk("post_we", 32'(regWe), 32'd1);
    chk("post_addr", 32'(regAddr), 32'd3);
    chk("post_retired", instrRetired, 32'd1);
    chk("post_sq_empty", 32'(memReq), 32'd0);
    chk("post_flush", 32'(flush), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
